// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, debug and data-memory buses around dmem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
);
   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W-1:0] core_rdata;
   logic              core_stall;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_ack;
   logic [DATA_W-1:0] dbg_rdata;

   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_memorywrite;
   logic              mem_memoryread;
   logic [DATA_W-1:0] mem_read_data;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  mem_read_data,
      output core_rdata, core_stall, dbg_ack, dbg_rdata,
      output mem_address, mem_write_data, mem_memorywrite, mem_memoryread
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output mem_read_data,
      input  core_rdata, core_stall, dbg_ack, dbg_rdata,
      input  mem_address, mem_write_data, mem_memorywrite, mem_memoryread
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter for the single-ported data memory: core has priority,
// a starvation counter forces a debug grant (and a one-cycle core stall).
module dmem_arbiter #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 64,
   parameter int MAX_WAIT = 4
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);
   localparam int               CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0]  wait_cnt;
   logic              dbg_ack_q;
   logic [DATA_W-1:0] dbg_rdata_q;
   logic              dbg_elig;
   logic              gnt_dbg;
   logic              gnt_core;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;
   logic              sel_re;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v >= WAIT_MAX) ? WAIT_MAX : v + 1'b1;
   endfunction

   // A request is not eligible in its own ack cycle, so it is never served twice.
   assign dbg_elig = bus.dbg_req & ~dbg_ack_q;
   assign gnt_dbg  = ~reset & dbg_elig & (~bus.core_req | (wait_cnt == WAIT_MAX));
   assign gnt_core = bus.core_req & ~gnt_dbg;

   always_comb begin
      sel_addr  = bus.core_addr;
      sel_wdata = bus.core_wdata;
      sel_we    = gnt_core & bus.core_we;
      sel_re    = gnt_core & ~bus.core_we;
      if (gnt_dbg) begin
         sel_addr  = bus.dbg_addr;
         sel_wdata = bus.dbg_wdata;
         sel_we    = bus.dbg_we;
         sel_re    = ~bus.dbg_we;
      end
   end

   assign bus.mem_address     = sel_addr;
   assign bus.mem_write_data  = sel_wdata;
   assign bus.mem_memorywrite = sel_we;
   assign bus.mem_memoryread  = sel_re;
   assign bus.core_rdata      = bus.mem_read_data;
   assign bus.core_stall      = bus.core_req & gnt_dbg;
   assign bus.dbg_ack         = dbg_ack_q;
   assign bus.dbg_rdata       = dbg_rdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt    <= '0;
         dbg_ack_q   <= 1'b0;
         dbg_rdata_q <= '0;
      end else begin
         dbg_ack_q <= gnt_dbg;
         if (gnt_dbg && !bus.dbg_we)
            dbg_rdata_q <= bus.mem_read_data;
         // Dropping the request abandons it and restarts the starvation count.
         if (gnt_dbg || !bus.dbg_req)
            wait_cnt <= '0;
         else if (dbg_elig && gnt_core)
            wait_cnt <= sat_inc(wait_cnt);
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, a randomized run against a
// behavioural model, and a MAX_WAIT=0 corner sequence on a second instance.
module tb_dmem_arbiter;
   localparam int DW = 64;
   localparam int AW = 64;
   localparam int MW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1;
   logic rst0;
   int   checks = 0;
   int   failures = 0;

   dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
   dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));
   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(0))  dut0 (.clk(clk), .reset(rst0), .bus(bus0));

   function automatic logic [63:0] pat(input int i);
      return 64'hA5A5_0000_0000_0000 | 64'(i);
   endfunction

   // Environment memory: pattern contents until a location is written.
   logic [63:0] mem1 [64];
   bit          wr1  [64];
   logic [5:0]  idx1;
   logic [5:0]  idx0;
   assign idx1 = bus1.mem_address[5:0];
   assign idx0 = bus0.mem_address[5:0];
   assign bus1.mem_read_data = wr1[idx1] ? mem1[idx1] : pat(int'(idx1));
   assign bus0.mem_read_data = pat(int'(idx0));

   always @(posedge clk) begin
      if (bus1.mem_memorywrite === 1'b1) begin
         mem1[idx1] <= bus1.mem_write_data;
         wr1[idx1]  <= 1'b1;
      end
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: denial streak, pending-ack flag, last debug read, memory image.
   int          m_wait = 0;
   bit          m_ack = 1'b0;
   logic [63:0] m_rdata = '0;
   logic [63:0] m_mem [64];
   bit          e_elig, e_gd, e_gc;
   logic        e_stall, e_we, e_re;
   logic [63:0] e_addr, e_wd;

   task automatic model_eval();
      e_elig  = (bus1.dbg_req === 1'b1) && !m_ack;
      e_gd    = !rst1 && e_elig && (bus1.core_req !== 1'b1 || m_wait >= MW);
      e_gc    = (bus1.core_req === 1'b1) && !e_gd;
      e_stall = (bus1.core_req === 1'b1) && e_gd;
      if (e_gd) begin
         e_addr = bus1.dbg_addr;
         e_wd   = bus1.dbg_wdata;
         e_we   = bus1.dbg_we;
         e_re   = !bus1.dbg_we;
      end else begin
         e_addr = bus1.core_addr;
         e_wd   = bus1.core_wdata;
         e_we   = e_gc && bus1.core_we;
         e_re   = e_gc && !bus1.core_we;
      end
   endtask

   task automatic model_commit();
      if (!rst1 && e_gd && !bus1.dbg_we) m_rdata = m_mem[e_addr[5:0]];
      if (e_we) m_mem[e_addr[5:0]] = e_wd;
      if (rst1) begin
         m_wait  = 0;
         m_ack   = 1'b0;
         m_rdata = '0;
      end else begin
         m_ack = e_gd;
         if (e_gd || bus1.dbg_req !== 1'b1) m_wait = 0;
         else if (e_elig && e_gc) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
      end
   endtask

   task automatic tick();
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic set1(input logic r, cq, cw, input logic [63:0] ca, cwd,
                       input logic dq, dw, input logic [63:0] da, dwd);
      rst1            = r;
      bus1.core_req   = cq;
      bus1.core_we    = cw;
      bus1.core_addr  = ca;
      bus1.core_wdata = cwd;
      bus1.dbg_req    = dq;
      bus1.dbg_we     = dw;
      bus1.dbg_addr   = da;
      bus1.dbg_wdata  = dwd;
   endtask

   task automatic check_model();
      chk1 ("rnd_core_stall", bus1.core_stall, e_stall);
      chk1 ("rnd_dbg_ack", bus1.dbg_ack, m_ack);
      chk64("rnd_dbg_rdata", bus1.dbg_rdata, m_rdata);
      chk64("rnd_mem_address", bus1.mem_address, e_addr);
      chk64("rnd_mem_write_data", bus1.mem_write_data, e_wd);
      chk1 ("rnd_mem_memorywrite", bus1.mem_memorywrite, e_we);
      chk1 ("rnd_mem_memoryread", bus1.mem_memoryread, e_re);
      chk64("rnd_core_rdata", bus1.core_rdata, m_mem[e_addr[5:0]]);
   endtask

   typedef struct {
      logic        r, cq, cw;
      logic [63:0] ca;
      logic        dq, dw;
      logic [63:0] da, dwd;
      logic        st, ak, we, re;
      logic [63:0] ea, erd;
   } vec_t;

   function automatic vec_t mk(input logic r, cq, cw, input logic [63:0] ca,
                               input logic dq, dw, input logic [63:0] da, dwd,
                               input logic st, ak, we, re, input logic [63:0] ea, erd);
      vec_t v;
      v.r = r;  v.cq = cq; v.cw = cw; v.ca = ca;
      v.dq = dq; v.dw = dw; v.da = da; v.dwd = dwd;
      v.st = st; v.ak = ak; v.we = we; v.re = re; v.ea = ea; v.erd = erd;
      return v;
   endfunction

   vec_t tbl [$];

   initial begin
      logic [63:0] p11, p13;
      bit          dq, dw;
      logic [63:0] da, dwd;

      for (int i = 0; i < 64; i++) m_mem[i] = pat(i);
      p11 = pat('h11);
      p13 = pat('h13);

      rst0 = 1'b1;
      bus0.core_req = 1'b0; bus0.core_we = 1'b0; bus0.core_addr = '0; bus0.core_wdata = '0;
      bus0.dbg_req  = 1'b0; bus0.dbg_we  = 1'b0; bus0.dbg_addr  = '0; bus0.dbg_wdata  = '0;
      set1(1, 1, 0, 0, 'hC0DE, 1, 1, 'h10, 'hDEAD);
      #1;
      model_eval();
      tick();

      // reset held with both requests high
      repeat (2) tbl.push_back(mk(1,1,0,'h00, 1,1,'h10,'hDEAD, 0,0,0,1,'h00,0));
      // idle debug write then read
      tbl.push_back(mk(0,0,0,'h00, 1,1,'h10,'hDEAD, 0,0,1,0,'h10,0));
      tbl.push_back(mk(0,0,0,'h00, 0,0,'h10,0,      0,1,0,0,'h00,0));
      tbl.push_back(mk(0,0,0,'h00, 1,0,'h10,0,      0,0,0,1,'h10,0));
      tbl.push_back(mk(0,0,0,'h00, 0,0,'h10,0,      0,1,0,0,'h00,'hDEAD));
      // starvation: core wins 4 cycles, then forced grant with one stall
      repeat (4) tbl.push_back(mk(0,1,0,'h20, 1,0,'h11,0, 0,0,0,1,'h20,'hDEAD));
      tbl.push_back(mk(0,1,0,'h20, 1,0,'h11,0, 1,0,0,1,'h11,'hDEAD));
      tbl.push_back(mk(0,1,0,'h20, 0,0,'h11,0, 0,1,0,1,'h20,p11));
      // held request: one access per two cycles
      tbl.push_back(mk(0,0,0,'h20, 1,1,'h12,'hBEEF, 0,0,1,0,'h12,p11));
      tbl.push_back(mk(0,0,0,'h20, 1,1,'h12,'hBEEF, 0,1,0,0,'h20,p11));
      tbl.push_back(mk(0,0,0,'h20, 1,1,'h12,'hBEEF, 0,0,1,0,'h12,p11));
      tbl.push_back(mk(0,0,0,'h20, 0,1,'h12,'hBEEF, 0,1,0,0,'h20,p11));
      // abandoned after 2 denials, new request waits the full 4 again
      repeat (2) tbl.push_back(mk(0,1,0,'h20, 1,0,'h13,0, 0,0,0,1,'h20,p11));
      tbl.push_back(mk(0,1,0,'h20, 0,0,'h13,0, 0,0,0,1,'h20,p11));
      repeat (4) tbl.push_back(mk(0,1,0,'h20, 1,0,'h13,0, 0,0,0,1,'h20,p11));
      tbl.push_back(mk(0,1,0,'h20, 1,0,'h13,0, 1,0,0,1,'h13,p11));
      tbl.push_back(mk(0,1,0,'h20, 0,0,'h13,0, 0,1,0,1,'h20,p13));
      // reset during a debug request drops it without an ack
      tbl.push_back(mk(1,0,0,'h20, 1,1,'h14,'h5555, 0,0,0,0,'h20,p13));
      tbl.push_back(mk(0,0,0,'h20, 0,0,'h14,0,      0,0,0,0,'h20,0));

      foreach (tbl[i]) begin
         set1(tbl[i].r, tbl[i].cq, tbl[i].cw, tbl[i].ca, 'hC0DE,
              tbl[i].dq, tbl[i].dw, tbl[i].da, tbl[i].dwd);
         #2;
         model_eval();
         chk1 ($sformatf("vec%0d_core_stall", i), bus1.core_stall, tbl[i].st);
         chk1 ($sformatf("vec%0d_dbg_ack", i), bus1.dbg_ack, tbl[i].ak);
         chk1 ($sformatf("vec%0d_mem_memorywrite", i), bus1.mem_memorywrite, tbl[i].we);
         chk1 ($sformatf("vec%0d_mem_memoryread", i), bus1.mem_memoryread, tbl[i].re);
         chk64($sformatf("vec%0d_mem_address", i), bus1.mem_address, tbl[i].ea);
         chk64($sformatf("vec%0d_dbg_rdata", i), bus1.dbg_rdata, tbl[i].erd);
         tick();
      end

      // randomized traffic against the model
      dq = 1'b0; dw = 1'b0; da = '0; dwd = '0;
      for (int c = 0; c < 3000; c++) begin
         if (m_ack) begin
            dq  = ($urandom_range(0, 1) == 1);
            dw  = ($urandom_range(0, 1) == 1);
            da  = 64'($urandom_range(0, 63));
            dwd = {$urandom, $urandom};
         end else if (!dq) begin
            if ($urandom_range(0, 2) == 0) begin
               dq  = 1'b1;
               dw  = ($urandom_range(0, 1) == 1);
               da  = 64'($urandom_range(0, 63));
               dwd = {$urandom, $urandom};
            end
         end else if ($urandom_range(0, 15) == 0) begin
            dq = 1'b0;
         end
         set1($urandom_range(0, 99) == 0,
              (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) != 0),
              $urandom_range(0, 1) == 1, 64'($urandom_range(0, 63)), {$urandom, $urandom},
              dq, dw, da, dwd);
         #2;
         model_eval();
         check_model();
         tick();
      end

      // MAX_WAIT=0: debug wins immediately, core load is served the next cycle
      rst0 = 1'b0;
      bus0.core_req = 1'b1; bus0.core_we = 1'b0; bus0.core_addr = 64'd5;
      bus0.dbg_req  = 1'b1; bus0.dbg_we  = 1'b0; bus0.dbg_addr  = 64'd7;
      #2;
      chk1 ("mw0_grant_core_stall", bus0.core_stall, 1'b1);
      chk1 ("mw0_grant_mem_memoryread", bus0.mem_memoryread, 1'b1);
      chk1 ("mw0_grant_mem_memorywrite", bus0.mem_memorywrite, 1'b0);
      chk64("mw0_grant_mem_address", bus0.mem_address, 64'd7);
      chk1 ("mw0_grant_dbg_ack", bus0.dbg_ack, 1'b0);
      @(posedge clk);
      #1;
      bus0.dbg_req = 1'b0;
      #2;
      chk1 ("mw0_next_core_stall", bus0.core_stall, 1'b0);
      chk1 ("mw0_next_mem_memoryread", bus0.mem_memoryread, 1'b1);
      chk64("mw0_next_mem_address", bus0.mem_address, 64'd5);
      chk64("mw0_next_core_rdata", bus0.core_rdata, pat(5));
      chk1 ("mw0_next_dbg_ack", bus0.dbg_ack, 1'b1);
      chk64("mw0_next_dbg_rdata", bus0.dbg_rdata, pat(7));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
